// File: rtl/dense_feeder_if.sv
// dense_feeder_if: pixel-in / row-out signal bundle for dense_feeder.
//   valid_i, sof_i, data_i : one pixel of D channels from the conv stage
//   data_o, valid_o        : packed row word and its one-cycle valid pulse
//   last_o                 : row is the last one of the frame
//   drop_o                 : a partial row/frame was discarded by sof_i
// Modports:
//   master : pixel source / row consumer side (drives the *_i signals)
//   slave  : dense_feeder side (drives the *_o signals)
interface dense_feeder_if #(
  parameter int DATA_WIDTH = 8,
  parameter int W          = 3,
  parameter int D          = 12
);
  logic                         valid_i;
  logic                         sof_i;
  logic [DATA_WIDTH*D-1:0]      data_i;
  logic [DATA_WIDTH*W*D-1:0]    data_o;
  logic                         valid_o;
  logic                         last_o;
  logic                         drop_o;

  modport master (
    output valid_i, sof_i, data_i,
    input  data_o, valid_o, last_o, drop_o
  );

  modport slave (
    input  valid_i, sof_i, data_i,
    output data_o, valid_o, last_o, drop_o
  );
endinterface

// File: rtl/dense_feeder.sv
// dense_feeder: packs W pixels (D channels of DATA_WIDTH bits each) into one
// row word for the first dense layer and flags the last row of each H-row
// frame.
// Ports:
//   clk  - clock
//   rstn - asynchronous active-low reset
//   bus  - dense_feeder_if.slave (valid_i, sof_i, data_i in;
//          data_o, valid_o, last_o, drop_o out)
// Optional build macro:
//   DENSE_FEED_RELU_EN - when defined, negative channel values are replaced
//                        by 0 before staging (no latency change).
module dense_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int H          = 3,
  parameter int W          = 3,
  parameter int D          = 12
) (
  input  logic          clk,
  input  logic          rstn,
  dense_feeder_if.slave bus
);

  localparam int PIX_W = DATA_WIDTH * D;
  localparam int ROW_W = PIX_W * W;
  localparam int CW    = (W > 1) ? $clog2(W) : 1;
  localparam int RW    = (H > 1) ? $clog2(H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(H - 1);

  logic [PIX_W-1:0]          pix_in;
  logic [W-1:0][PIX_W-1:0]   stage;
  logic [CW-1:0]             col_cnt;
  logic [CW-1:0]             col_eff;
  logic [RW-1:0]             row_cnt;
  logic [RW-1:0]             row_eff;
  logic                      row_done;
  logic                      stale;
  logic [ROW_W-1:0]          row_word;

  logic [ROW_W-1:0]          data_q;
  logic                      valid_q;
  logic                      last_q;
  logic                      drop_q;

`ifdef DENSE_FEED_RELU_EN
  always_comb begin
    pix_in = bus.data_i;
    for (int c = 0; c < D; c++) begin
      if (bus.data_i[c*DATA_WIDTH + DATA_WIDTH - 1])
        pix_in[c*DATA_WIDTH +: DATA_WIDTH] = '0;
    end
  end
`else
  always_comb begin
    pix_in = bus.data_i;
  end
`endif

  // A start-of-frame beat behaves as if the counters were already at 0,0,
  // so it lands in slot 0 of row 0 regardless of what was pending.
  always_comb begin
    col_eff  = bus.sof_i ? '0 : col_cnt;
    row_eff  = bus.sof_i ? '0 : row_cnt;
    row_done = bus.valid_i && (col_eff == COL_LAST);
    stale    = bus.valid_i && bus.sof_i && ((col_cnt != '0) || (row_cnt != '0));
  end

  // Completed word: staged slots plus the current beat in its own slot.
  // After an sof, stale slots 1..W-2 are always overwritten before the
  // row can complete, so they never reach data_o.
  always_comb begin
    row_word = '0;
    for (int p = 0; p < W; p++) begin
      if (CW'(p) == col_eff)
        row_word[p*PIX_W +: PIX_W] = pix_in;
      else
        row_word[p*PIX_W +: PIX_W] = stage[p];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stage   <= '0;
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (bus.valid_i) begin
      if (row_done) begin
        col_cnt <= '0;
        row_cnt <= (row_eff == ROW_LAST) ? '0 : row_eff + RW'(1);
      end else begin
        stage[col_eff] <= pix_in;
        col_cnt        <= col_eff + CW'(1);
        row_cnt        <= row_eff;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      valid_q <= row_done;
      last_q  <= row_done && (row_eff == ROW_LAST);
      drop_q  <= stale;
      if (row_done)
        data_q <= row_word;
    end
  end

  assign bus.data_o  = data_q;
  assign bus.valid_o = valid_q;
  assign bus.last_o  = last_q;
  assign bus.drop_o  = drop_q;

endmodule

// File: tb/tb_dense_feeder.sv
// tb_dense_feeder: self-checking bench for dense_feeder (W=3, D=12, H=3).
// A reference model of the column/row counters pushes expected row words
// into a scoreboard queue as beats are driven; words are popped and
// compared when valid_o appears. Build with or without DENSE_FEED_RELU_EN.
module tb_dense_feeder;

  localparam int DW    = 8;
  localparam int H     = 3;
  localparam int W     = 3;
  localparam int D     = 12;
  localparam int PW    = DW * D;
  localparam int ROW_W = PW * W;

  typedef struct packed {
    logic [ROW_W-1:0] data;
    logic             last;
  } exp_t;

  logic clk;
  logic rstn;

  dense_feeder_if #(.DATA_WIDTH(DW), .W(W), .D(D)) bus ();

  dense_feeder #(.DATA_WIDTH(DW), .H(H), .W(W), .D(D)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int               compared;
  int               mismatched;
  exp_t             sb_q[$];
  logic [PW-1:0]    m_stage [W];
  int               m_col;
  int               m_row;
  logic [ROW_W-1:0] held;
  int               pulses;
  int               drops;
  logic [7:0]       last_bits;
  logic [ROW_W-1:0] got_rows [6];
  logic [ROW_W-1:0] ref_rows [3];

  function automatic logic [PW-1:0] relu_pix(input logic [PW-1:0] px);
    logic [PW-1:0] r;
    r = px;
`ifdef DENSE_FEED_RELU_EN
    for (int c = 0; c < D; c++)
      if (px[c*DW + DW - 1]) r[c*DW +: DW] = '0;
`endif
    return r;
  endfunction

  function automatic logic [PW-1:0] ramp_pix(input int k);
    logic [PW-1:0] r;
    for (int c = 0; c < D; c++) r[c*DW +: DW] = 8'(16 * k + c);
    return r;
  endfunction

  function automatic logic [PW-1:0] fill_pix(input logic [7:0] b);
    logic [PW-1:0] r;
    for (int c = 0; c < D; c++) r[c*DW +: DW] = b;
    return r;
  endfunction

  task automatic clear_model();
    m_col = 0;
    m_row = 0;
    for (int p = 0; p < W; p++) m_stage[p] = '0;
    held = '0;
    sb_q.delete();
  endtask

  task automatic reset_stats();
    pulses    = 0;
    drops     = 0;
    last_bits = '0;
  endtask

  // Drive one cycle (beat or idle) and check every output #1 after the edge.
  task automatic step(input logic v, input logic s, input logic [PW-1:0] px);
    logic          exp_v;
    logic          exp_drop;
    int            col;
    int            row;
    logic [PW-1:0] rp;
    exp_t          e;
    exp_t          got;
    exp_v    = 1'b0;
    exp_drop = 1'b0;
    bus.valid_i = v;
    bus.sof_i   = s;
    bus.data_i  = px;
    if (v) begin
      col = s ? 0 : m_col;
      row = s ? 0 : m_row;
      if (s && (m_col != 0 || m_row != 0)) exp_drop = 1'b1;
      rp = relu_pix(px);
      if (col == W - 1) begin
        for (int p = 0; p < W; p++)
          e.data[p*PW +: PW] = (p == col) ? rp : m_stage[p];
        e.last = (row == H - 1);
        sb_q.push_back(e);
        exp_v = 1'b1;
        m_col = 0;
        m_row = (row == H - 1) ? 0 : row + 1;
      end else begin
        m_stage[col] = rp;
        m_col = col + 1;
        m_row = row;
      end
    end
    @(posedge clk);
    #1;
    bus.valid_i = 1'b0;
    bus.sof_i   = 1'b0;
    compared++;
    if (bus.valid_o !== exp_v) begin
      mismatched++;
      $display("FAIL valid_o: got %b expected %b at %0t", bus.valid_o, exp_v, $time);
    end
    compared++;
    if (bus.drop_o !== exp_drop) begin
      mismatched++;
      $display("FAIL drop_o: got %b expected %b at %0t", bus.drop_o, exp_drop, $time);
    end
    if (bus.drop_o === 1'b1) drops++;
    if (bus.valid_o === 1'b1) begin
      compared++;
      if (sb_q.size() == 0) begin
        mismatched++;
        $display("FAIL row_word: unexpected valid_o with empty scoreboard at %0t", $time);
      end else begin
        got = sb_q.pop_front();
        if (bus.data_o !== got.data) begin
          mismatched++;
          $display("FAIL row_word: got %h expected %h", bus.data_o, got.data);
        end
        compared++;
        if (bus.last_o !== got.last) begin
          mismatched++;
          $display("FAIL last_o: got %b expected %b at %0t", bus.last_o, got.last, $time);
        end
        held = got.data;
      end
      if (pulses < 6) got_rows[pulses] = bus.data_o;
      if (bus.last_o === 1'b1 && pulses < 8) last_bits[pulses] = 1'b1;
      pulses++;
    end else begin
      compared++;
      if (bus.data_o !== held) begin
        mismatched++;
        $display("FAIL data_hold: got %h expected %h", bus.data_o, held);
      end
      compared++;
      if (bus.last_o !== 1'b0) begin
        mismatched++;
        $display("FAIL last_idle: got %b expected 0", bus.last_o);
      end
    end
  endtask

  task automatic apply_reset();
    bus.valid_i = 1'b0;
    bus.sof_i   = 1'b0;
    rstn = 1'b0;
    #1;
    compared += 4;
    if (bus.data_o !== '0) begin
      mismatched++;
      $display("FAIL rst_data: got %h expected 0", bus.data_o);
    end
    if (bus.valid_o !== 1'b0) begin
      mismatched++;
      $display("FAIL rst_valid: got %b expected 0", bus.valid_o);
    end
    if (bus.last_o !== 1'b0) begin
      mismatched++;
      $display("FAIL rst_last: got %b expected 0", bus.last_o);
    end
    if (bus.drop_o !== 1'b0) begin
      mismatched++;
      $display("FAIL rst_drop: got %b expected 0", bus.drop_o);
    end
    @(posedge clk);
    #1;
    rstn = 1'b1;
    clear_model();
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    compared++;
    if (got != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic check_vec(input string name, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    reset_stats();
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, fill_pix(8'h55));
  endtask

  task automatic test_back_to_back();
    logic [7:0] b0;
    logic [7:0] b35;
    reset_stats();
    for (int k = 0; k < 9; k++) step(1'b1, k == 0, ramp_pix(k));
    check_int("b2b_pulses", pulses, 3);
    check_int("b2b_last_bits", int'(last_bits), 4);
    check_int("b2b_drops", drops, 0);
    for (int r = 0; r < 3; r++) ref_rows[r] = got_rows[r];
    b0  = got_rows[0][7:0];
    b35 = got_rows[0][35*8 +: 8];
    check_int("b2b_row0_byte0", int'(b0), 'h00);
    check_int("b2b_row0_byte35", int'(b35), 'h2B);
  endtask

  task automatic test_gaps();
    reset_stats();
    for (int k = 0; k < 9; k++) begin
      step(1'b1, k == 0, ramp_pix(k));
      step(1'b0, 1'b0, '0);
      step(1'b0, 1'b0, '0);
    end
    check_int("gap_pulses", pulses, 3);
    check_int("gap_last_bits", int'(last_bits), 4);
    for (int r = 0; r < 3; r++) begin
      compared++;
      if (got_rows[r] !== ref_rows[r]) begin
        mismatched++;
        $display("FAIL gap_row%0d: got %h expected %h", r, got_rows[r], ref_rows[r]);
      end
    end
  endtask

  task automatic test_sof_drop();
    reset_stats();
    step(1'b1, 1'b0, fill_pix(8'h11));
    step(1'b1, 1'b0, fill_pix(8'h22));
    step(1'b1, 1'b1, fill_pix(8'hAA));
    step(1'b1, 1'b0, fill_pix(8'h33));
    step(1'b1, 1'b0, fill_pix(8'h44));
    check_int("sof_drops", drops, 1);
    check_int("sof_pulses", pulses, 1);
    check_vec("sof_pix0", got_rows[0][0 +: PW], relu_pix(fill_pix(8'hAA)));
    check_vec("sof_pix1", got_rows[0][PW +: PW], relu_pix(fill_pix(8'h33)));
    check_vec("sof_pix2", got_rows[0][2*PW +: PW], relu_pix(fill_pix(8'h44)));
  endtask

  task automatic test_reset_mid();
    reset_stats();
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0, ramp_pix(k + 10));
    apply_reset();
    reset_stats();
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, ramp_pix(k + 20));
    check_int("rmid_pulses", pulses, 1);
    check_int("rmid_last_bits", int'(last_bits), 0);
    check_vec("rmid_pix0", got_rows[0][0 +: PW], relu_pix(ramp_pix(20)));
  endtask

  task automatic test_continuous();
    apply_reset();
    reset_stats();
    for (int k = 0; k < 18; k++) step(1'b1, k == 0, ramp_pix(k));
    check_int("cont_pulses", pulses, 6);
    check_int("cont_last_bits", int'(last_bits), 'h24);
    check_int("cont_drops", drops, 0);
  endtask

  task automatic test_relu();
    logic [PW-1:0] px;
    logic [31:0]   exp_b;
    reset_stats();
    for (int c = 0; c < D; c++)
      case (c % 4)
        0: px[c*DW +: DW] = 8'h80;
        1: px[c*DW +: DW] = 8'hFF;
        2: px[c*DW +: DW] = 8'h7F;
        default: px[c*DW +: DW] = 8'h01;
      endcase
    for (int k = 0; k < 3; k++) step(1'b1, k == 0, px);
    check_int("relu_pulses", pulses, 1);
`ifdef DENSE_FEED_RELU_EN
    exp_b = 32'h01_7F_00_00;
`else
    exp_b = 32'h01_7F_FF_80;
`endif
    compared++;
    if (got_rows[0][31:0] !== exp_b) begin
      mismatched++;
      $display("FAIL relu_bytes: got %h expected %h", got_rows[0][31:0], exp_b);
    end
    compared++;
    if (got_rows[0][2*PW +: 32] !== exp_b) begin
      mismatched++;
      $display("FAIL relu_bytes_pix2: got %h expected %h", got_rows[0][2*PW +: 32], exp_b);
    end
  endtask

  initial begin
    compared    = 0;
    mismatched  = 0;
    rstn        = 1'b1;
    bus.valid_i = 1'b0;
    bus.sof_i   = 1'b0;
    bus.data_i  = '0;
    clear_model();
    reset_stats();
    @(posedge clk);
    #1;
    test_reset();
    test_back_to_back();
    test_gaps();
    test_sof_drop();
    test_reset_mid();
    test_continuous();
    test_relu();
    step(1'b0, 1'b0, '0);
    compared++;
    if (sb_q.size() != 0) begin
      mismatched++;
      $display("FAIL sb_drain: %0d rows still expected, 0 required", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
